// File: rtl/frame_scheduler.sv
// -----------------------------------------------------------------------------
// frame_scheduler
//
// Double-buffer sequencer that sits between the sprite driver, the two
// framebuffers and the screen drivers. It owns front/back buffer selection,
// clears the back buffer to CLEAR_COLOR before every draw pass, starts the
// sprite driver's draw pass and swaps buffers on the global vsync once the
// draw pass has finished.
//
// Ports (all on the rising edge of clock):
//   clock          in   pixel clock
//   reset          in   synchronous, active-high, highest priority
//   vsync          in   global vsync (same clock domain), polarity set by
//                       VSYNC_ACTIVE_LOW
//   draw_done      in   sprite driver: draw pass finished and queue empty
//   front_sel      out  displayed buffer (0 = buffer 1, 1 = buffer 2)
//   clear_we       out  per-buffer clear write enable (bit0 = buf 1, bit1 = buf 2)
//   clear_addr     out  clear write address
//   clear_data     out  clear colour (constant CLEAR_COLOR)
//   fb_resetting   out  high while a clear is writing; sprite driver must idle
//   draw_start     out  one-cycle pulse: back buffer cleared, begin drawing
//   frame_count    out  completed swaps, wraps 65535 -> 0
//   overrun_count  out  vsync events that could not swap, saturates at 255
// -----------------------------------------------------------------------------
module frame_scheduler #(
  parameter int         ADDR_W           = 19,
  parameter int         FB_PIXELS        = 307200,
  parameter logic [3:0] CLEAR_COLOR      = 4'h0,
  parameter bit         VSYNC_ACTIVE_LOW = 1'b1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              vsync,
  input  logic              draw_done,
  output logic              front_sel,
  output logic [1:0]        clear_we,
  output logic [ADDR_W-1:0] clear_addr,
  output logic [3:0]        clear_data,
  output logic              fb_resetting,
  output logic              draw_start,
  output logic [15:0]       frame_count,
  output logic [7:0]        overrun_count
);

  typedef enum logic [1:0] {
    S_INIT,
    S_CLEAR,
    S_DRAW,
    S_WAIT_VSYNC
  } state_e;

  localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(FB_PIXELS - 1);
  localparam logic              VSYNC_IDLE = VSYNC_ACTIVE_LOW;

  state_e              state_q, state_d;
  logic                vsync_q;
  logic                front_sel_q, front_sel_d;
  logic [1:0]          clear_we_q, clear_we_d;
  logic [ADDR_W-1:0]   clear_addr_q, clear_addr_d;
  logic                fb_resetting_q, fb_resetting_d;
  logic                draw_start_q, draw_start_d;
  logic [15:0]         frame_count_q, frame_count_d;
  logic [7:0]          overrun_count_q, overrun_count_d;

  logic                vs_evt;
  logic                swap;
  logic                missed;

  // Single-cycle strobe on the transition into the active vsync level.
  assign vs_evt = VSYNC_ACTIVE_LOW ? (vsync_q & ~vsync) : (~vsync_q & vsync);

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_d         = state_q;
    front_sel_d     = front_sel_q;
    clear_we_d      = 2'b00;
    clear_addr_d    = '0;
    fb_resetting_d  = 1'b0;
    draw_start_d    = 1'b0;
    frame_count_d   = frame_count_q;
    overrun_count_d = overrun_count_q;
    swap            = 1'b0;
    missed          = 1'b0;

    // The clear outputs are computed one cycle ahead, so the registered
    // clear_we/clear_addr pair is the write actually happening this cycle.
    case (state_q)
      S_INIT, S_CLEAR: begin
        missed = vs_evt;
        if (state_q == S_INIT && !fb_resetting_q) begin
          // First cycle out of reset: start the dual-buffer clear at 0.
          clear_we_d     = 2'b11;
          fb_resetting_d = 1'b1;
        end else if (clear_addr_q == LAST_ADDR) begin
          state_d      = S_DRAW;
          draw_start_d = 1'b1;
        end else begin
          clear_we_d     = clear_we_q;
          clear_addr_d   = clear_addr_q + ADDR_W'(1);
          fb_resetting_d = 1'b1;
        end
      end
      S_DRAW: begin
        if (vs_evt && draw_done) begin
          swap = 1'b1;
        end else if (vs_evt) begin
          missed = 1'b1;
        end else if (draw_done) begin
          state_d = S_WAIT_VSYNC;
        end
      end
      S_WAIT_VSYNC: begin
        swap = vs_evt;
      end
      default: state_d = S_INIT;
    endcase

    if (swap) begin
      // The old front becomes the new back buffer, so it is the one cleared;
      // the first clear write lands in the same cycle the new front shows.
      state_d        = S_CLEAR;
      front_sel_d    = ~front_sel_q;
      frame_count_d  = frame_count_q + 16'd1;
      clear_we_d     = front_sel_q ? 2'b10 : 2'b01;
      clear_addr_d   = '0;
      fb_resetting_d = 1'b1;
    end

    if (missed && overrun_count_q != 8'hFF) begin
      overrun_count_d = overrun_count_q + 8'd1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of process ordering.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q         <= S_INIT;
      vsync_q         <= VSYNC_IDLE;
      front_sel_q     <= 1'b0;
      clear_we_q      <= 2'b00;
      clear_addr_q    <= '0;
      fb_resetting_q  <= 1'b0;
      draw_start_q    <= 1'b0;
      frame_count_q   <= 16'd0;
      overrun_count_q <= 8'd0;
    end else begin
      state_q         <= state_d;
      vsync_q         <= vsync;
      front_sel_q     <= front_sel_d;
      clear_we_q      <= clear_we_d;
      clear_addr_q    <= clear_addr_d;
      fb_resetting_q  <= fb_resetting_d;
      draw_start_q    <= draw_start_d;
      frame_count_q   <= frame_count_d;
      overrun_count_q <= overrun_count_d;
    end
  end

  assign front_sel     = front_sel_q;
  assign clear_we      = clear_we_q;
  assign clear_addr    = clear_addr_q;
  assign clear_data    = CLEAR_COLOR;
  assign fb_resetting  = fb_resetting_q;
  assign draw_start    = draw_start_q;
  assign frame_count   = frame_count_q;
  assign overrun_count = overrun_count_q;

endmodule

// File: doc/frame_scheduler.md
Name: frame_scheduler

Overview:
Double-buffer sequencer between the sprite driver, the framebuffers and the screen drivers. It owns front/back buffer selection and clears the back buffer to a background colour each frame. It starts the sprite driver's draw pass and swaps buffers on the global vsync once drawing completes. It runs on the pixel clock and drives the framebuffer write-port enables during the clear.

Parameters:
ADDR_W, 19, framebuffer address width
FB_PIXELS, 307200, pixels per buffer (640x480); the clear walks addresses 0..FB_PIXELS-1
CLEAR_COLOR, 4'h0, colour index written during a clear
VSYNC_ACTIVE_LOW, 1, polarity of the vsync input

Ports:
clock  in  1  pixel clock; all logic is on its rising edge
reset  in  1  synchronous, active-high
vsync  in  1  global vsync from the screen driver, same clock domain
draw_done  in  1  level from the sprite driver: draw pass finished and queue empty
front_sel  out  1  buffer being displayed (0 = buffer 1, 1 = buffer 2); back = ~front_sel
clear_we  out  2  per-buffer write enable during a clear; bit0 = buffer 1, bit1 = buffer 2
clear_addr  out  ADDR_W  clear write address
clear_data  out  4  always CLEAR_COLOR
fb_resetting  out  1  high while any clear is in progress; sprite driver must not write
draw_start  out  1  one-cycle pulse: back buffer cleared, begin draw pass
frame_count  out  16  completed swaps, wraps at 65535 -> 0
overrun_count  out  8  vsync events missed, saturates at 255

Behaviour:
- All outputs are registered. Reset is synchronous and has priority over everything.
- Reset values: front_sel=0, clear_we=2'b00, clear_addr=0, fb_resetting=0, draw_start=0, frame_count=0, overrun_count=0, state=INIT.
- The vsync edge detector register resets to the inactive level. vs_evt is the single-cycle assertion edge: falling edge if VSYNC_ACTIVE_LOW, else rising edge.
- FSM states: INIT, CLEAR, DRAW, WAIT_VSYNC.
- INIT (the first cycle after reset deasserts):
  - clear_we=2'b11, fb_resetting=1.
  - clear_addr steps 0,1,...,FB_PIXELS-1, one write per cycle.
  - After the write at FB_PIXELS-1: clear_we=0, fb_resetting=0, go to DRAW. draw_start is high in the first DRAW cycle.
  - INIT lasts exactly FB_PIXELS write cycles.
- CLEAR: same address walk as INIT, but clear_we is one-hot on the back buffer only (2'b01 if front_sel=1, 2'b10 if front_sel=0). Exits to DRAW with a draw_start pulse in the same way.
- DRAW:
  - Waits for draw_done=1, then goes to WAIT_VSYNC.
  - If vs_evt and draw_done occur in the same cycle, swap immediately: toggle front_sel, increment frame_count, go to CLEAR. Nothing is added to overrun_count.
  - vs_evt with draw_done=0 increments overrun_count (saturating) and the state stays DRAW.
- WAIT_VSYNC: on vs_evt, toggle front_sel, increment frame_count, go to CLEAR. draw_done is ignored in this state.
- A vs_evt during INIT or CLEAR increments overrun_count (saturating). The clear continues; no swap occurs.
- front_sel changes only in the cycle after a vs_evt, so the screen drivers see the new buffer from the start of vertical blanking.
- clear_addr returns to 0 whenever the FSM is not in INIT or CLEAR; clear_we is 0 outside those states.
- Timing from a swap-triggering vs_evt (cycle t):
  - front_sel toggles and the first clear write occurs at t+1.
  - The last clear write occurs at t+FB_PIXELS.
  - draw_start is high at t+FB_PIXELS+1.
- Reset asserted mid-clear or mid-draw: the next cycle is in reset state. The clear restarts from INIT at address 0; there is no partial swap.
- draw_done asserted with no draw pass pending (INIT or CLEAR) is ignored.

Test Plan:
(bench uses FB_PIXELS=16, VSYNC_ACTIVE_LOW=1)
1. Release reset, hold vsync=1, draw_done=0 -> clear_we=2'b11 for exactly 16 cycles with clear_addr 0..15 and clear_data=0; fb_resetting high for the same 16 cycles; draw_start pulses once on cycle 17; front_sel=0.
2. From DRAW, raise draw_done, then drive a vsync 1->0 edge -> front_sel becomes 1 the next cycle; frame_count=1; clear_we=2'b01 for 16 cycles; draw_start pulses afterwards.
3. In DRAW with draw_done=0, drive 3 vsync falling edges -> overrun_count=3, front_sel unchanged, frame_count unchanged. Then draw_done=1 and a 4th edge -> swap occurs, overrun_count stays 3.
4. draw_done rises in the same cycle as a vsync falling edge while in DRAW -> immediate swap and CLEAR, overrun_count unchanged.
5. Assert reset at clear address 7 of a CLEAR -> next cycle all outputs at reset values; after release INIT clears both buffers from address 0.
6. Force 300 missed vsyncs -> overrun_count saturates at 255. Run 65536 swaps -> frame_count wraps to 0.
